bellek_erisim_denetleyici: RTL and testbench

- Initiator-side controller for the 16x16 dual-edge memory block. The memory writes on the rising edge and reads on the falling edge.
- Accepts burst read/write commands over a valid/ready command channel.
- Streams write data in and read data out over valid/ready channels.
- Drives the memory's we/adres/yaz pins and consumes its oku output.

---
 rtl/bellek_pkg.sv | 15 +
 rtl/cift_yonlu_bellek.sv | 28 ++
 rtl/bellek_erisim_denetleyici.sv | 100 ++++++++++
 tb/tb_bellek_erisim_denetleyici.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bellek_pkg.sv
// Shared definitions for the memory access controller and its 16x16 dual-edge memory.
// State encoding and default geometry live here so the controller and the memory agree.
package bellek_pkg;

   localparam int unsigned BELLEK_ADDR_W   = 4;
   localparam int unsigned BELLEK_DATA_W   = 16;
   localparam int unsigned BELLEK_DERINLIK = 16;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWrite = 2'd1,
      StRead  = 2'd2
   } durum_e;

endpackage

// File: rtl/cift_yonlu_bellek.sv
// 16x16 dual-edge memory: stores on the rising edge, presents the addressed word on the
// falling edge so a controller can consume it before the next rising edge.
module cift_yonlu_bellek
   import bellek_pkg::*;
#(
   parameter int unsigned ADDR_W = BELLEK_ADDR_W,
   parameter int unsigned DATA_W = BELLEK_DATA_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] adres,
   input  logic [DATA_W-1:0] yaz,
   output logic [DATA_W-1:0] oku
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[adres] <= yaz;
      end
   end

   always_ff @(negedge clk) begin
      oku <= mem[adres];
   end

endmodule

// File: rtl/bellek_erisim_denetleyici.sv
// Initiator-side burst controller for the dual-edge memory: accepts read/write bursts
// and streams one word per cycle over valid/ready data channels.
module bellek_erisim_denetleyici
   import bellek_pkg::*;
#(
   parameter int unsigned ADDR_W = BELLEK_ADDR_W,
   parameter int unsigned DATA_W = BELLEK_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W-1:0] cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              done,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_adres,
   output logic [DATA_W-1:0] mem_yaz,
   input  logic [DATA_W-1:0] mem_oku
);

   durum_e            durum_q, durum_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              beat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         durum_q <= StIdle;
         addr_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         durum_q <= durum_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // cnt_q holds beats remaining minus one, so the beat seen with cnt_q == 0 is the last.
   always_comb begin
      durum_d = durum_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      beat    = 1'b0;
      unique case (durum_q)
         StIdle: begin
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               cnt_d   = cmd_len;
               durum_d = cmd_write ? StWrite : StRead;
            end
         end
         StWrite: beat = wr_valid;
         StRead:  beat = rd_ready;
         default: durum_d = StIdle;
      endcase
      if (beat) begin
         addr_d = addr_q + 1'b1;
         cnt_d  = cnt_q - 1'b1;
         if (cnt_q == '0) begin
            durum_d = StIdle;
            done_d  = 1'b1;
         end
      end
   end

   always_comb begin
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      rd_valid  = 1'b0;
      mem_we    = 1'b0;
      unique case (durum_q)
         StIdle:  cmd_ready = 1'b1;
         StWrite: begin
            wr_ready = 1'b1;
            mem_we   = wr_valid;
         end
         StRead:  rd_valid = 1'b1;
         default: ;
      endcase
   end

   // The memory refreshes oku on the falling edge after addr_q moves, so it feeds rd_data directly.
   assign mem_adres = addr_q;
   assign mem_yaz   = wr_data;
   assign rd_data   = mem_oku;
   assign done      = done_q;

endmodule

// File: tb/tb_bellek_erisim_denetleyici.sv
// Closed subsystem bench: controller plus dual-edge memory, checked every cycle against a
// burst-level model, with directed scenarios and randomized bursts.
module tb_bellek_erisim_denetleyici;
   import bellek_pkg::*;

   logic        clk, rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [3:0]  cmd_addr, cmd_len;
   logic        wr_valid, wr_ready;
   logic [15:0] wr_data;
   logic        rd_valid, rd_ready;
   logic [15:0] rd_data;
   logic        done, mem_we;
   logic [3:0]  mem_adres;
   logic [15:0] mem_yaz, mem_oku;

   bellek_erisim_denetleyici #(.ADDR_W(4), .DATA_W(16)) u_dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .done(done), .mem_we(mem_we), .mem_adres(mem_adres), .mem_yaz(mem_yaz),
      .mem_oku(mem_oku)
   );

   cift_yonlu_bellek #(.ADDR_W(4), .DATA_W(16)) u_mem (
      .clk(clk), .we(mem_we), .adres(mem_adres), .yaz(mem_yaz), .oku(mem_oku)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Burst-level model: mode 0 idle, 1 writing, 2 reading; m_left = words still owed.
   int          m_mode = 0;
   int          m_left = 0;
   logic [3:0]  m_addr = '0;
   logic        m_done = 1'b0;
   logic [15:0] m_mem [16];
   bit          m_known [16];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode <= 0;
         m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_mode == 0 && cmd_valid) begin
            m_mode <= cmd_write ? 1 : 2;
            m_addr <= cmd_addr;
            m_left <= int'(cmd_len) + 1;
         end else if ((m_mode == 1 && wr_valid) || (m_mode == 2 && rd_ready)) begin
            if (m_mode == 1) begin
               m_mem[m_addr]   <= wr_data;
               m_known[m_addr] <= 1'b1;
            end
            m_addr <= m_addr + 4'd1;
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_mode <= 0;
               m_done <= 1'b1;
            end
         end
      end
   end

   bit          chk_on = 1'b0;
   int          we_cnt = 0;
   int          done_cnt = 0;
   int          cyc = 0;
   logic [15:0] rd_log [$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      #1;
      if (chk_on) begin
         chk("cmd_ready", 32'(cmd_ready), 32'(m_mode == 0));
         chk("wr_ready", 32'(wr_ready), 32'(m_mode == 1));
         chk("rd_valid", 32'(rd_valid), 32'(m_mode == 2));
         chk("mem_we", 32'(mem_we), 32'(m_mode == 1 && wr_valid));
         chk("done", 32'(done), 32'(m_done));
         if (m_mode != 0) chk("mem_adres", 32'(mem_adres), 32'(m_addr));
         if (m_mode == 1) chk("mem_yaz", 32'(mem_yaz), 32'(wr_data));
         if (m_mode == 2 && m_known[m_addr]) chk("rd_data", 32'(rd_data), 32'(m_mem[m_addr]));
         if (rd_valid && rd_ready) rd_log.push_back(rd_data);
         if (mem_we) we_cnt++;
         if (done) done_cnt++;
      end
   end

   logic [15:0] wdata [16];
   logic        bp_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int budget = 60;
      while (m_mode != 0 && budget > 0) begin
         step();
         budget--;
      end
      if (m_mode != 0) chk("idle_timeout", 32'(m_mode), 32'd0);
   endtask

   task automatic send_cmd(input logic w, input logic [3:0] a, input logic [3:0] l);
      wait_idle();
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_len   = l;
      step();
      cmd_valid = 1'b0;
      cmd_addr  = 4'($urandom);
      cmd_len   = 4'($urandom);
   endtask

   // bub: 0 none, 1 two idle cycles before beat index 2, 2 random idle cycles
   task automatic do_write(input logic [3:0] a, input logic [3:0] l, input int bub);
      send_cmd(1'b1, a, l);
      for (int i = 0; i <= int'(l); i++) begin
         int gaps = 0;
         if (bub == 1 && i == 2) gaps = 2;
         if (bub == 2) gaps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         for (int g = 0; g < gaps; g++) begin
            wr_valid = 1'b0;
            wr_data  = 16'($urandom);
            step();
         end
         wr_valid = 1'b1;
         wr_data  = wdata[i];
         step();
      end
      wr_valid = 1'b0;
   endtask

   // pat: 0 always ready, 1 fixed stall pattern, 2 random ready
   task automatic do_read(input logic [3:0] a, input logic [3:0] l, input int pat);
      int target = rd_log.size() + int'(l) + 1;
      int budget = 200;
      int i = 0;
      send_cmd(1'b0, a, l);
      while (rd_log.size() < target && budget > 0) begin
         if (pat == 0) rd_ready = 1'b1;
         else if (pat == 1) rd_ready = (i < 5) ? bp_pat[i] : 1'b1;
         else rd_ready = ($urandom_range(0, 3) != 0);
         step();
         i++;
         budget--;
      end
      rd_ready = 1'b0;
      if (rd_log.size() < target) chk("read_timeout", 32'(rd_log.size()), 32'(target));
   endtask

   initial begin
      int w0, d0, s, c0;
      rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      #1 rst = 1'b1;
      chk_on = 1'b1;
      repeat (2) step();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      step();

      // single write then read
      w0 = we_cnt; d0 = done_cnt;
      wdata[0] = 16'hA5A5;
      do_write(4'd3, 4'd0, 0);
      do_read(4'd3, 4'd0, 0);
      step();
      chk("single_rd", 32'(rd_log[rd_log.size() - 1]), 32'hA5A5);
      chk("single_we_cycles", 32'(we_cnt - w0), 32'd1);
      chk("single_done_pulses", 32'(done_cnt - d0), 32'd2);

      // full 16-word burst, one word per cycle
      for (int i = 0; i < 16; i++) wdata[i] = 16'(i) * 16'h0101;
      do_write(4'd0, 4'd15, 0);
      s = rd_log.size();
      c0 = cyc;
      do_read(4'd0, 4'd15, 0);
      chk("full_cycles", 32'(cyc - c0), 32'd17);
      chk("full_beats", 32'(rd_log.size() - s), 32'd16);
      for (int i = 0; i < 16; i++) chk("full_rd", 32'(rd_log[s + i]), 32'(16'(i) * 16'h0101));

      // backpressure on a 3-word read
      s = rd_log.size();
      do_read(4'd8, 4'd2, 1);
      chk("bp_beats", 32'(rd_log.size() - s), 32'd3);
      chk("bp_rd0", 32'(rd_log[s]), 32'h0808);
      chk("bp_rd1", 32'(rd_log[s + 1]), 32'h0909);
      chk("bp_rd2", 32'(rd_log[s + 2]), 32'h0A0A);

      // address wrap 14,15,0,1
      for (int i = 0; i < 4; i++) wdata[i] = 16'(i + 1);
      do_write(4'd14, 4'd3, 0);
      s = rd_log.size();
      do_read(4'd14, 4'd3, 0);
      for (int i = 0; i < 4; i++) chk("wrap_rd", 32'(rd_log[s + i]), 32'(i + 1));

      // write bubbles
      wdata[0] = 16'h0011; wdata[1] = 16'h0022; wdata[2] = 16'h0033; wdata[3] = 16'h0044;
      w0 = we_cnt;
      do_write(4'd4, 4'd3, 1);
      chk("bubble_we_cycles", 32'(we_cnt - w0), 32'd4);
      s = rd_log.size();
      do_read(4'd4, 4'd3, 0);
      chk("bubble_rd0", 32'(rd_log[s]), 32'h0011);
      chk("bubble_rd3", 32'(rd_log[s + 3]), 32'h0044);

      // reset during the second beat of a 4-word write
      step();
      w0 = we_cnt; d0 = done_cnt;
      send_cmd(1'b1, 4'd4, 4'd3);
      wr_valid = 1'b1; wr_data = 16'h00D0;
      step();
      wr_data = 16'h00D1;
      #1 rst = 1'b1;
      #1;
      chk("midrst_mem_we", 32'(mem_we), 32'd0);
      chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      step();
      step();
      wr_valid = 1'b0;
      rst = 1'b0;
      step();
      chk("midrst_done", 32'(done_cnt - d0), 32'd0);
      chk("midrst_we_cycles", 32'(we_cnt - w0), 32'd1);
      s = rd_log.size();
      do_read(4'd4, 4'd3, 0);
      chk("midrst_rd0", 32'(rd_log[s]), 32'h00D0);
      chk("midrst_rd1", 32'(rd_log[s + 1]), 32'h0022);
      chk("midrst_rd2", 32'(rd_log[s + 2]), 32'h0033);
      chk("midrst_rd3", 32'(rd_log[s + 3]), 32'h0044);

      // randomized bursts
      for (int n = 0; n < 40; n++) begin
         logic [3:0] a, l;
         a = 4'($urandom);
         l = 4'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < 16; i++) wdata[i] = 16'($urandom);
            do_write(a, l, 2);
         end else begin
            do_read(a, l, 2);
         end
      end
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
